// File: rtl/scan7seg_mux_if.sv
// Display-data load channel for scan7seg_mux: front-panel logic is master, the scanner is slave.
interface scan7seg_mux_if #(parameter int DIGITS = 4);
  logic                  load;
  logic                  ready;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;

  modport master (output load, digits_in, dp_in, blank_in, input ready);
  modport slave  (input load, digits_in, dp_in, blank_in, output ready);
endinterface

// File: rtl/scan7seg_mux.sv
// Multiplexed 7-segment scanner: hex decode, dp, blanking, PWM, double-buffered loads.
// Define SCAN7SEG_LZ_BLANK_EN to suppress leading-zero digits.
module scan7seg_dec (
    input  logic [3:0] nib,
    output logic [6:0] segs
);
    always_comb begin
        segs = 7'b0000000;
        case (nib)
            4'h0: segs = 7'b1111110;
            4'h1: segs = 7'b0110000;
            4'h2: segs = 7'b1101101;
            4'h3: segs = 7'b1111001;
            4'h4: segs = 7'b0110011;
            4'h5: segs = 7'b1011011;
            4'h6: segs = 7'b1011111;
            4'h7: segs = 7'b1110000;
            4'h8: segs = 7'b1111111;
            4'h9: segs = 7'b1111011;
            4'hA: segs = 7'b1110111;
            4'hB: segs = 7'b0011111;
            4'hC: segs = 7'b1001110;
            4'hD: segs = 7'b0111101;
            4'hE: segs = 7'b1001111;
            4'hF: segs = 7'b1000111;
            default: segs = 7'b0000000;
        endcase
    end
endmodule

module scan7seg_mux #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 12,
    parameter int DUTY_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    scan7seg_mux_if.slave     bus,
    input  logic [DUTY_W-1:0] brightness,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] way
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef struct packed {
        logic [DIGITS-1:0][3:0] dig;
        logic [DIGITS-1:0]      dp;
        logic [DIGITS-1:0]      blank;
    } disp_t;

    logic [PRESCALE_W-1:0]  pre;
    logic [IDX_W-1:0]       idx;
    logic                   pend;
    disp_t                  pend_d, shad;
    logic [DIGITS-1:0][6:0] dec;
    logic [DIGITS-1:0]      lz;
    logic                   wrap, frame_end, lit;
    logic [DUTY_W-1:0]      phase;

    assign wrap      = &pre;
    assign frame_end = wrap && (idx == IDX_W'(DIGITS-1));
    assign phase     = pre[PRESCALE_W-1 -: DUTY_W];
    assign bus.ready = ~pend;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dec
        scan7seg_dec u_dec (.nib(shad.dig[i]), .segs(dec[i]));
    end

`ifdef SCAN7SEG_LZ_BLANK_EN
    // Walk down from the top digit; digit 0 is never suppressed so "0" still shows.
    always_comb begin
        logic run;
        lz  = '0;
        run = 1'b1;
        for (int i = DIGITS-1; i > 0; i--) begin
            run   = run & (shad.dig[i] == 4'h0);
            lz[i] = run;
        end
    end
`else
    assign lz = '0;
`endif

    assign lit = !shad.blank[idx] && (phase <= brightness);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre + 1'b1;
            if (wrap) idx <= frame_end ? '0 : idx + IDX_W'(1);
        end
    end

    // Copy wins over capture; both can never apply in one cycle since capture needs pend=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            pend_d <= '0;
            shad   <= '{dig: '0, dp: '0, blank: '1};
        end else if (frame_end && pend) begin
            pend <= 1'b0;
            shad <= pend_d;
        end else if (bus.load && !pend) begin
            pend   <= 1'b1;
            pend_d <= '{dig: bus.digits_in, dp: bus.dp_in, blank: bus.blank_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= '0;
            way <= '0;
        end else begin
            way <= {{(DIGITS-1){1'b0}}, 1'b1} << idx;
            seg <= lit ? {dec[idx] & ~{7{lz[idx]}}, shad.dp[idx]} : 8'h00;
        end
    end
endmodule

// File: tb/tb_scan7seg_mux.sv
// Directed bench for scan7seg_mux with DIGITS=4, PRESCALE_W=4, DUTY_W=2 (16-clock slot, 64-clock frame).
module tb_scan7seg_mux;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] brightness = 2'd3;
    logic [7:0] seg;
    logic [3:0] way;
    int         checks = 0;
    int         errors = 0;
    int         tcnt;

    scan7seg_mux_if #(.DIGITS(4)) bus ();

    scan7seg_mux #(.DIGITS(4), .PRESCALE_W(4), .DUTY_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .brightness(brightness), .seg(seg), .way(way)
    );

    always #5 clk = ~clk;

    // Edges since reset release; outputs after edge n reflect scan position n-1.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tcnt <= 0;
        else        tcnt <= tcnt + 1;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic align(input int m);
        for (int g = 0; g < 70 && (tcnt % 64) != m; g++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        int g;
        g = 0;
        while (!bus.ready && g < 200) begin step(); g++; end
        bus.digits_in = d; bus.dp_in = p; bus.blank_in = b; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        g = 0;
        while (!bus.ready && g < 200) begin step(); g++; end
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL load_timeout ready=%b required 1", bus.ready); end
    endtask

    task automatic test_reset();
        logic [12:0] e;
        bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_in = '0;
        repeat (3) step();
        checks++;
        if ({seg, way, bus.ready} !== {8'h00, 4'h0, 1'b1}) begin
            errors++; $display("FAIL reset_state seg=%h way=%b ready=%b required 00 0000 1", seg, way, bus.ready);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 128; j++) begin
            step();
            e = {4'b0001 << ((j / 16) % 4), 8'h00, 1'b1};
            checks++;
            if ({way, seg, bus.ready} !== e) begin
                errors++; $display("FAIL scan_idle j=%0d got %b required %b", j, {way, seg, bus.ready}, e);
            end
        end
    endtask

    task automatic test_handshake();
        logic [7:0]  ex [4];
        logic [11:0] e;
        int          early;
        ex[0] = 8'b01100001; ex[1] = 8'b11110111; ex[2] = 8'b11111110; ex[3] = 8'b11011010;
        align(20);
        bus.digits_in = 16'h2891; bus.dp_in = 4'b0011; bus.blank_in = 4'b0000; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL ready_after_accept got %b required 0", bus.ready); end
        early = 0;
        for (int g = 0; g < 200 && (tcnt % 64) != 0; g++) begin
            step();
            if ((tcnt % 64) != 0 && bus.ready !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL ready_early cycles=%0d required 0", early); end
        checks++;
        if (bus.ready !== 1'b1 || (tcnt % 64) != 0) begin
            errors++; $display("FAIL ready_return ready=%b pos=%0d required 1 at 0", bus.ready, tcnt % 64);
        end
        for (int j = 0; j < 64; j++) begin
            step();
            e = {4'b0001 << (j / 16), ex[j / 16]};
            checks++;
            if ({way, seg} !== e) begin errors++; $display("FAIL frame_2891 j=%0d got %b required %b", j, {way, seg}, e); end
        end
    endtask

    task automatic test_pwm();
        logic [7:0]  ex [4];
        logic [11:0] e;
        ex[0] = 8'b01100001; ex[1] = 8'b11110111; ex[2] = 8'b11111110; ex[3] = 8'b11011010;
        align(0);
        for (int br = 0; br < 3; br += 2) begin
            brightness = 2'(br);
            for (int j = 0; j < 64; j++) begin
                step();
                e = {4'b0001 << (j / 16), (((j % 16) / 4) <= br) ? ex[j / 16] : 8'h00};
                checks++;
                if ({way, seg} !== e) begin
                    errors++; $display("FAIL pwm_b%0d j=%0d got %b required %b", br, j, {way, seg}, e);
                end
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        int g;
        align(5);
        bus.digits_in = 16'h1111; bus.dp_in = 4'b0000; bus.blank_in = 4'b0000; bus.load = 1'b1;
        step();
        bus.digits_in = 16'hEEEE; bus.dp_in = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_ready k=%0d got %b required 0", k, bus.ready); end
        end
        bus.load = 1'b0;
        g = 0;
        while (!bus.ready && g < 200) begin step(); g++; end
        for (int j = 0; j < 128; j++) begin
            step();
            e = {4'b0001 << ((j / 16) % 4), 8'b01100000};
            checks++;
            if ({way, seg} !== e) begin errors++; $display("FAIL b2b_frame j=%0d got %b required %b", j, {way, seg}, e); end
        end
    endtask

    task automatic test_boundary_load();
        logic [7:0]  ex [4];
        logic [11:0] e;
        ex[0] = 8'h00; ex[1] = 8'hFF; ex[2] = 8'h00; ex[3] = 8'hFF;
        align(63);
        bus.digits_in = 16'h8888; bus.dp_in = 4'b1111; bus.blank_in = 4'b0101; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL bnd_accept ready=%b required 0", bus.ready); end
        step();
        checks++;
        if ({way, seg} !== {4'b0001, 8'b01100000}) begin
            errors++; $display("FAIL bnd_old_data got %b required 000101100000", {way, seg});
        end
        align(63);
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL bnd_hold ready=%b required 0", bus.ready); end
        step();
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL bnd_release ready=%b required 1", bus.ready); end
        for (int j = 0; j < 64; j++) begin
            step();
            e = {4'b0001 << (j / 16), ex[j / 16]};
            checks++;
            if ({way, seg} !== e) begin errors++; $display("FAIL blank_frame j=%0d got %b required %b", j, {way, seg}, e); end
        end
    endtask

    task automatic test_lz();
        logic [7:0]  ex [4];
        logic [11:0] e;
        do_load(16'h0050, 4'b0000, 4'b0000);
`ifdef SCAN7SEG_LZ_BLANK_EN
        ex[0] = 8'b11111100; ex[1] = 8'b10110110; ex[2] = 8'h00; ex[3] = 8'h00;
`else
        ex[0] = 8'b11111100; ex[1] = 8'b10110110; ex[2] = 8'b11111100; ex[3] = 8'b11111100;
`endif
        for (int j = 0; j < 64; j++) begin
            step();
            e = {4'b0001 << (j / 16), ex[j / 16]};
            checks++;
            if ({way, seg} !== e) begin errors++; $display("FAIL lz_0050 j=%0d got %b required %b", j, {way, seg}, e); end
        end
        do_load(16'h0000, 4'b0000, 4'b0000);
`ifdef SCAN7SEG_LZ_BLANK_EN
        ex[1] = 8'h00;
`else
        ex[1] = 8'b11111100;
`endif
        for (int j = 0; j < 64; j++) begin
            step();
            e = {4'b0001 << (j / 16), ex[j / 16]};
            checks++;
            if ({way, seg} !== e) begin errors++; $display("FAIL lz_0000 j=%0d got %b required %b", j, {way, seg}, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        align(10);
        bus.digits_in = 16'h2891; bus.dp_in = 4'b0011; bus.blank_in = 4'b0000; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_pending ready=%b required 0", bus.ready); end
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({seg, way, bus.ready} !== {8'h00, 4'h0, 1'b1}) begin
            errors++; $display("FAIL mid_reset seg=%h way=%b ready=%b required 00 0000 1", seg, way, bus.ready);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int j = 0; j < 192; j++) begin
            step();
            e = {4'b0001 << ((j / 16) % 4), 8'h00, 1'b1};
            checks++;
            if ({way, seg, bus.ready} !== e) begin
                errors++; $display("FAIL after_mid_reset j=%0d got %b required %b", j, {way, seg, bus.ready}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_pwm();
        test_back_to_back();
        test_boundary_load();
        test_lz();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan7seg_mux.md
Name: scan7seg_mux

Overview:
- Parametrised multiplexed 7-segment display scanner for DIGITS common-select digits.
- Decodes 4-bit hex per digit, with per-digit decimal point, per-digit blanking and PWM brightness.
- Display data is double-buffered through a ready/load handshake, so updates never tear mid-frame.
- Sits between front-panel logic (counters, BCD results) and the board digit-select and segment pins.

Parameters:
- DIGITS, 4: number of digits scanned; must be at least 2.
- PRESCALE_W, 12: each digit slot lasts 2^PRESCALE_W clocks.
- DUTY_W, 3: brightness resolution in bits; must be less than PRESCALE_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  request to capture new display data; accepted when load and ready are both high
- digits_in  in  4*DIGITS  hex nibble per digit; digit i is digits_in[4i+3:4i]
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit dark, including dp
- brightness  in  DUTY_W  0 = dimmest, all-ones = full on; sampled live every clock
- ready  out  1  1 = a load will be accepted
- seg  out  8  segment drive, active high; seg[7..0] = a,b,c,d,e,f,g,dp
- way  out  DIGITS  digit select, one-hot, active high; way[i] selects digit i

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - seg=0, way=0, ready=1.
  - Prescaler=0, digit index=0, pending flag=0.
  - Shadow digits=0, shadow dp=0, shadow blank=all 1s.
- Scan:
  - PRESCALE_W-bit prescaler increments every clock.
  - When the prescaler wraps (all 1s to 0), the digit index advances 0,1,...,DIGITS-1,0.
  - Slot = 2^PRESCALE_W clocks; frame = DIGITS slots.
- Outputs:
  - seg and way are registered from the current prescaler and index.
  - On the first edge after reset release, way[0]=1.
  - way holds its one-hot value for the whole slot.
  - Slot changes produce no overlapping or all-zero way cycles.
- PWM:
  - phase = top DUTY_W bits of the prescaler.
  - seg = decoded value when phase <= brightness, else 8'h00; way is not gated.
  - Each slot therefore lights (brightness+1)*2^(PRESCALE_W-DUTY_W) consecutive clocks, starting at the first clock of the slot.
- Decode of a..g (seg[7:1]):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - seg[0] = shadow dp of the digit.
  - Shadow blank=1 forces seg=8'h00.
- Handshake:
  - load && ready: capture digits_in, dp_in, blank_in into pending registers; ready=0 from the next cycle.
  - load while ready=0 is ignored and the data is discarded.
  - Pending data is copied to the shadow registers on the frame boundary clock (prescaler wraps with index=DIGITS-1). The first slot of the new frame shows the new data.
  - ready returns to 1 on the cycle after the copy.
  - If load is accepted on the frame boundary clock itself, the data is applied at the following frame boundary, not the current one.
- Reset mid-operation: all state returns to reset values immediately; pending data is lost.

Optional Feature:
- Macro: SCAN7SEG_LZ_BLANK_EN.
- Defined:
  - Leading-zero suppression: starting from digit DIGITS-1 downward, each digit whose shadow nibble is 0 has seg[7:1] forced to 0.
  - Suppression stops at the first non-zero digit; digit 0 is never suppressed.
  - dp and the PWM gating are unaffected.
- Undefined: all digits are decoded normally. The port list is identical in both builds.

Test Plan (DIGITS=4, PRESCALE_W=4, DUTY_W=2: slot 16 clocks, frame 64 clocks):
- Reset then release, no load -> seg=0, way=0 in reset, ready=1; after release way cycles 0001,0010,0100,1000, 16 clocks each; seg stays 8'h00.
- load=1 for one cycle with digits_in=16'h2891, dp_in=4'b0011, blank_in=0, brightness=3 -> ready=0 until the frame boundary, then ready=1 one cycle later. Next frame shows:
  - way=0001: seg=01100001
  - way=0010: seg=11110111
  - way=0100: seg=11111110
  - way=1000: seg=11011010
- Same data, brightness=0 -> seg is non-zero only in the first 4 clocks of each 16-clock slot. brightness=2 -> 12 clocks.
- Accept load of 16'h1111, then while ready=0 pulse load with 16'hEEEE -> display shows 1111; EEEE never appears.
- Assert rst_n=0 mid-slot with pending data -> seg=0, way=0, ready=1 immediately. After release the display stays blank; the pending data is never applied.
- With SCAN7SEG_LZ_BLANK_EN defined:
  - 16'h0050 -> digits 3 and 2 show seg=0; digit 1 shows 10110110; digit 0 shows 11111100.
  - 16'h0000 -> only digit 0 lit, showing 11111100.
  - With the macro undefined, all digits show 11111100 for the zero digits.
